fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Sequencer that owns the program-counter register of the single-cycle RISC-V core and drives instruction fetch over a req/ack memory port. It loads the address produced by the combinational next-PC block when the current instruction commits. It detects a self-loop jump as a halt and a misaligned target as a fault, and keeps cycle and retired-instruction counters. It sits between the `next_pc` logic, the instruction memory and the decode/execute datapath.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `CNT_W`, 32: width of `cycle_cnt` and `instret_cnt`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `next_pc` in 32: target from the next-PC logic for the instruction held in EXEC.
- `commit` in 1: the current instruction retires this cycle.
- `stall` in 1: blocks commit while high.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address; always equals `pc`.
- `imem_ack` in 1: memory returns `imem_rdata` this cycle.
- `imem_rdata` in 32: fetched instruction word.
- `pc` out 32: architectural PC.
- `instr` out 32: latched instruction.
- `instr_valid` out 1: `instr` is valid for execute.
- `halted` out 1: sticky halt.
- `fault` out 1: sticky misaligned-target fault.
- `fault_addr` out 32: the offending `next_pc`.
- `cycle_cnt` out CNT_W: cycles since reset.
- `instret_cnt` out CNT_W: retired instructions.

## Operation
- FSM states: IDLE, FETCH, EXEC, HALT, FAULT.
- Reset values:
  - state = IDLE.
  - `pc` = RESET_PC.
  - `instr` = 32'h0000_0013 (NOP).
  - `instr_valid`, `imem_req`, `halted`, `fault` = 0.
  - `fault_addr`, `cycle_cnt`, `instret_cnt` = 0.
- IDLE → FETCH unconditionally on the next cycle.
- FETCH:
  - `imem_req` = 1.
  - On `imem_ack`: `instr` <= `imem_rdata`, then → EXEC.
  - Without ack: stay in FETCH; no timeout.
- EXEC:
  - `instr_valid` = 1.
  - On `commit && !stall`, apply in this priority:
    - `next_pc[1:0] != 0`: → FAULT, `fault_addr` <= `next_pc`, `pc` unchanged, `instret_cnt` unchanged.
    - `next_pc == pc`: → HALT, `pc` unchanged, `instret_cnt` += 1.
    - Otherwise: `pc` <= `next_pc`, `instret_cnt` += 1, → FETCH.
  - `commit` while `stall` is high is ignored; the core stays in EXEC.
- HALT and FAULT are terminal until `rst`.
  - `halted` or `fault` = 1 respectively.
  - `imem_req` = 0, `instr_valid` = 0.
- Ignored inputs:
  - `imem_ack` outside FETCH.
  - `commit` outside EXEC.
- Counters:
  - `cycle_cnt` += 1 every cycle with `rst` = 0, including HALT and FAULT.
  - Both counters wrap modulo 2^CNT_W with no saturation.
- `imem_req`, `instr_valid`, `halted` and `fault` are decoded from the registered state only (Moore). They never depend combinationally on inputs.

## Timing
- Fetch latency: `instr_valid` rises the cycle after the ack edge. Minimum is 1 cycle in FETCH when ack is returned in the first request cycle.
- Minimum instruction period: 2 cycles (FETCH, EXEC).
- The PC update and the start of the next request are visible the cycle after the commit edge.
- `imem_addr` is stable for the entire request.
- `rst` mid-fetch:
  - `imem_req` = 0 from the next cycle.
  - A late ack arriving in IDLE is discarded.
- `rst` in EXEC with `commit`: reset wins; `pc` = RESET_PC.
- The first request after reset is asserted 2 cycles after `rst` deasserts (IDLE, then FETCH).

## Structure
- Shared package `fetch_pkg`:
  - State enum.
  - `NOP_INSTR` = 32'h0000_0013.
  - Default `RESET_PC`.
- Sub-module `perf_counter` (parameter W; ports `clk`, `rst`, `inc`, `count`) is instantiated twice, for cycles and for retired instructions.
- All FSM and PC logic is in the top module.

## Test plan
- Reset, then ack on the first request cycle with `imem_rdata` = 32'h0050_0093:
  - `imem_req` 0,0,1; `instr_valid` rises the following cycle with `instr` = 32'h0050_0093.
  - `imem_addr` = 0.
- `commit` with `next_pc` = 0x4, then `next_pc` = 0x40 (taken branch), with ack delayed 3 cycles each:
  - `pc` sequence 0x0 → 0x4 → 0x40; `instret_cnt` = 2.
  - `imem_req` is held high for 4 cycles per fetch.
- In EXEC with `stall` = 1 and `commit` = 1 for 5 cycles:
  - `pc` unchanged, `instret_cnt` unchanged.
  - Dropping `stall` then advances the PC on the next edge.
- At `pc` = 0x94, `commit` with `next_pc` = 0x94:
  - `halted` = 1, `imem_req` stays 0, `instret_cnt` increments once.
  - `cycle_cnt` keeps counting.
- `commit` with `next_pc` = 0x0000_0102:
  - `fault` = 1, `fault_addr` = 0x102, `pc` holds the old value.
  - After `rst`: `fault` = 0 and `pc` = RESET_PC.
- Wrap test with CNT_W = 4: after 16 retires `instret_cnt` = 0; `rst` asserted mid-FETCH drops the request and a late ack is ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_HALT  = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instruction targets must be word aligned; the low two bits flag a fault.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_sequencer_perf_counter.sv
// Free-running event counter, wraps modulo 2^W.
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // Count qualified events; cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// PC owner and instruction-fetch sequencer for the single-cycle core.
//
//   state | meaning
//   IDLE  | one dead cycle after reset before the first request
//   FETCH | imem_req high at pc, waiting for imem_ack
//   EXEC  | instr valid, waiting for an unstalled commit
//   HALT  | self-loop jump retired, terminal until rst
//   FAULT | misaligned target seen, terminal until rst
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      next_pc,
  input  logic             commit,
  input  logic             stall,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      pc,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic             halted,
  output logic             fault,
  output logic [31:0]      fault_addr,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [31:0]  r_fault_addr;
  logic         r_imem_req;
  logic         r_instr_valid;
  logic         r_halted;
  logic         r_fault;

  logic         w_exec_commit;
  logic         w_retire;

  assign w_exec_commit = (r_state == ST_EXEC) && commit && !stall;
  // A faulting commit does not retire; halt does.
  assign w_retire      = w_exec_commit && !is_misaligned(next_pc);

  // State, PC and the Moore output flags, all updated together so the flags
  // always match the state they are decoded from.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= NOP_INSTR;
      r_fault_addr  <= 32'h0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state    <= ST_FETCH;
          r_imem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            r_instr       <= imem_rdata;
            r_state       <= ST_EXEC;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (w_exec_commit) begin
            r_instr_valid <= 1'b0;
            if (is_misaligned(next_pc)) begin
              r_state      <= ST_FAULT;
              r_fault      <= 1'b1;
              r_fault_addr <= next_pc;
            end else if (next_pc == r_pc) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end else begin
              r_pc       <= next_pc;
              r_state    <= ST_FETCH;
              r_imem_req <= 1'b1;
            end
          end
        end
        ST_HALT, ST_FAULT: begin
          r_state <= r_state;
        end
        default: begin
          r_state       <= ST_IDLE;
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
          r_halted      <= 1'b0;
          r_fault       <= 1'b0;
        end
      endcase
    end
  end

  perf_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .count (cycle_cnt)
  );

  perf_counter #(.W(CNT_W)) u_instret_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_retire),
    .count (instret_cnt)
  );

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign halted      = r_halted;
  assign fault       = r_fault;
  assign fault_addr  = r_fault_addr;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; a second instance with 4-bit counters
// shares the stimulus so counter wrap can be observed.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;
  logic        commit;
  logic        stall;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        imem_req, instr_valid, halted, fault;
  logic [31:0] imem_addr, pc, instr, fault_addr;
  logic [31:0] cycle_cnt, instret_cnt;

  logic        s_imem_req, s_instr_valid, s_halted, s_fault;
  logic [31:0] s_imem_addr, s_pc, s_instr, s_fault_addr;
  logic [3:0]  s_cycle_cnt, s_instret_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned exp_cyc = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .next_pc(next_pc), .commit(commit), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .pc(pc), .instr(instr), .instr_valid(instr_valid),
    .halted(halted), .fault(fault), .fault_addr(fault_addr),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  fetch_sequencer #(.RESET_PC(32'h0), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .next_pc(next_pc), .commit(commit), .stall(stall),
    .imem_req(s_imem_req), .imem_addr(s_imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .pc(s_pc), .instr(s_instr), .instr_valid(s_instr_valid),
    .halted(s_halted), .fault(s_fault), .fault_addr(s_fault_addr),
    .cycle_cnt(s_cycle_cnt), .instret_cnt(s_instret_cnt)
  );

  // Advance one clock; outputs are sampled and inputs changed 1ns after the edge.
  task automatic step();
    @(posedge clk);
    if (rst) exp_cyc = 0;
    else     exp_cyc = exp_cyc + 1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; commit = 1'b0; stall = 1'b0; imem_ack = 1'b0;
    next_pc = 32'h0; imem_rdata = 32'h0;
    step(); step();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h expected 0", pc); end
    n_cmp++; if (instr !== 32'h0000_0013) begin n_err++; $display("FAIL reset_instr: got %h expected 00000013", instr); end
    n_cmp++; if ({instr_valid, halted, fault} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {instr_valid, halted, fault}); end
    n_cmp++; if (fault_addr !== 32'h0 || cycle_cnt !== 32'h0 || instret_cnt !== 32'h0) begin
      n_err++; $display("FAIL reset_regs: got fa=%h cyc=%0d ret=%0d expected 0/0/0", fault_addr, cycle_cnt, instret_cnt);
    end
    rst = 1'b0;
    // This cycle is IDLE: still no request.
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL idle_req: got %b expected 0", imem_req); end
    step();
  endtask

  task automatic test_first_fetch();
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %b expected 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL first_addr: got %h expected 0", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    n_cmp++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
      n_err++; $display("FAIL first_valid: got valid=%b req=%b expected 1/0", instr_valid, imem_req);
    end
    n_cmp++; if (instr !== 32'h0050_0093) begin n_err++; $display("FAIL first_instr: got %h expected 00500093", instr); end
    n_cmp++; if (cycle_cnt !== 32'd2) begin n_err++; $display("FAIL first_cycles: got %0d expected 2", cycle_cnt); end
  endtask

  // Commit from EXEC to target, then serve a fetch acked on the 4th request cycle.
  task automatic commit_and_slow_fetch(input logic [31:0] target, input logic [31:0] word,
                                       input logic [31:0] exp_ret);
    commit = 1'b1; next_pc = target;
    step();
    commit = 1'b0;
    n_cmp++; if (pc !== target) begin n_err++; $display("FAIL seq_pc: got %h expected %h", pc, target); end
    n_cmp++; if (instret_cnt !== exp_ret) begin n_err++; $display("FAIL seq_instret: got %0d expected %0d", instret_cnt, exp_ret); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== target || instr_valid !== 1'b0) begin
        n_err++; $display("FAIL seq_req_hold%0d: got req=%b addr=%h valid=%b expected 1/%h/0", i, imem_req, imem_addr, instr_valid, target);
      end
      if (i == 3) begin imem_ack = 1'b1; imem_rdata = word; end
      step();
    end
    imem_ack = 1'b0;
    n_cmp++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== word) begin
      n_err++; $display("FAIL seq_exec: got valid=%b req=%b instr=%h expected 1/0/%h", instr_valid, imem_req, instr, word);
    end
  endtask

  task automatic test_fetch_sequence();
    commit_and_slow_fetch(32'h4, 32'h0010_0113, 32'd1);
    commit_and_slow_fetch(32'h40, 32'h0020_0193, 32'd2);
  endtask

  task automatic test_stall();
    stall = 1'b1; commit = 1'b1; next_pc = 32'h44;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (pc !== 32'h40 || instret_cnt !== 32'd2 || instr_valid !== 1'b1) begin
        n_err++; $display("FAIL stall_hold%0d: got pc=%h ret=%0d valid=%b expected 40/2/1", i, pc, instret_cnt, instr_valid);
      end
    end
    stall = 1'b0;
    step();
    commit = 1'b0;
    n_cmp++; if (pc !== 32'h44 || instret_cnt !== 32'd3 || imem_req !== 1'b1) begin
      n_err++; $display("FAIL stall_release: got pc=%h ret=%0d req=%b expected 44/3/1", pc, instret_cnt, imem_req);
    end
  endtask

  task automatic test_halt();
    imem_ack = 1'b1; step(); imem_ack = 1'b0;
    commit = 1'b1; next_pc = 32'h94; step(); commit = 1'b0;
    imem_ack = 1'b1; step(); imem_ack = 1'b0;
    n_cmp++; if (pc !== 32'h94 || instr_valid !== 1'b1) begin
      n_err++; $display("FAIL halt_setup: got pc=%h valid=%b expected 94/1", pc, instr_valid);
    end
    commit = 1'b1; next_pc = 32'h94;
    step();
    n_cmp++; if (halted !== 1'b1 || fault !== 1'b0 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL halt_flags: got h=%b f=%b req=%b valid=%b expected 1/0/0/0", halted, fault, imem_req, instr_valid);
    end
    n_cmp++; if (pc !== 32'h94 || instret_cnt !== 32'd5) begin
      n_err++; $display("FAIL halt_pc_ret: got pc=%h ret=%0d expected 94/5", pc, instret_cnt);
    end
    // Commits and acks while halted must do nothing.
    imem_ack = 1'b1; next_pc = 32'h98;
    for (int i = 0; i < 3; i++) step();
    commit = 1'b0; imem_ack = 1'b0;
    n_cmp++; if (halted !== 1'b1 || imem_req !== 1'b0 || instret_cnt !== 32'd5 || pc !== 32'h94) begin
      n_err++; $display("FAIL halt_sticky: got h=%b req=%b ret=%0d pc=%h expected 1/0/5/94", halted, imem_req, instret_cnt, pc);
    end
    n_cmp++; if (cycle_cnt !== exp_cyc) begin n_err++; $display("FAIL halt_cycles: got %0d expected %0d", cycle_cnt, exp_cyc); end
  endtask

  task automatic test_fault();
    rst = 1'b1; step(); rst = 1'b0;
    step();
    imem_ack = 1'b1; step(); imem_ack = 1'b0;
    commit = 1'b1; next_pc = 32'h100; step(); commit = 1'b0;
    imem_ack = 1'b1; step(); imem_ack = 1'b0;
    commit = 1'b1; next_pc = 32'h0000_0102;
    step();
    commit = 1'b0;
    n_cmp++; if (fault !== 1'b1 || halted !== 1'b0 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL fault_flags: got f=%b h=%b req=%b valid=%b expected 1/0/0/0", fault, halted, imem_req, instr_valid);
    end
    n_cmp++; if (fault_addr !== 32'h102 || pc !== 32'h100 || instret_cnt !== 32'd1) begin
      n_err++; $display("FAIL fault_regs: got fa=%h pc=%h ret=%0d expected 102/100/1", fault_addr, pc, instret_cnt);
    end
    // Reset issued together with a commit: reset must win.
    rst = 1'b1; commit = 1'b1; next_pc = 32'h200;
    step();
    commit = 1'b0;
    n_cmp++; if (fault !== 1'b0 || pc !== 32'h0 || fault_addr !== 32'h0) begin
      n_err++; $display("FAIL fault_reset: got f=%b pc=%h fa=%h expected 0/0/0", fault, pc, fault_addr);
    end
  endtask

  task automatic test_wrap_and_reset_mid_fetch();
    logic [31:0] exp_pc;
    exp_pc = 32'h0;
    rst = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      imem_ack = 1'b1; imem_rdata = 32'h0000_0013; step(); imem_ack = 1'b0;
      exp_pc = exp_pc + 32'h4;
      commit = 1'b1; next_pc = exp_pc; step(); commit = 1'b0;
    end
    n_cmp++; if (s_instret_cnt !== 4'd0) begin n_err++; $display("FAIL wrap_instret4: got %0d expected 0", s_instret_cnt); end
    n_cmp++; if (instret_cnt !== 32'd16) begin n_err++; $display("FAIL wrap_instret32: got %0d expected 16", instret_cnt); end
    n_cmp++; if (s_cycle_cnt !== exp_cyc[3:0] || cycle_cnt !== exp_cyc) begin
      n_err++; $display("FAIL wrap_cycles: got %0d/%0d expected %0d/%0d", s_cycle_cnt, cycle_cnt, exp_cyc[3:0], exp_cyc);
    end
    n_cmp++; if (imem_req !== 1'b1 || pc !== 32'h40) begin
      n_err++; $display("FAIL wrap_fetch: got req=%b pc=%h expected 1/40", imem_req, pc);
    end
    rst = 1'b1;
    step();
    n_cmp++; if (imem_req !== 1'b0 || pc !== 32'h0) begin
      n_err++; $display("FAIL midfetch_drop: got req=%b pc=%h expected 0/0", imem_req, pc);
    end
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0BAD;
    step();
    imem_ack = 1'b0;
    n_cmp++; if (instr !== 32'h0000_0013 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
      n_err++; $display("FAIL late_ack: got instr=%h valid=%b req=%b expected 00000013/0/1", instr, instr_valid, imem_req);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_fetch_sequence();
    test_stall();
    test_halt();
    test_fault();
    test_wrap_and_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
